jump_ctrl: RTL

JUMP_CTRL -- requirements
Module: jump_ctrl

---
 rtl/jump_ctrl_if.sv | 33 +++
 rtl/jump_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/jump_ctrl_if.sv
// Request/flag inputs and PC-load/status outputs of the jump controller.
interface jump_ctrl_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [5:0]      PcIn;
  logic            JmpEn;
  logic            CondEn;
  logic [1:0]      CondSel;
  logic            ZeroFlag;
  logic            CarryFlag;
  logic            CallEn;
  logic            RetEn;
  logic [5:0]      Target;
  logic            ClrErr;
  logic            WriteEnable;
  logic [5:0]      AddrIn;
  logic            Flush;
  logic [CntW-1:0] Depth;
  logic            Overflow;
  logic            Underflow;

  modport master (
    output PcIn, JmpEn, CondEn, CondSel, ZeroFlag, CarryFlag, CallEn, RetEn, Target, ClrErr,
    input  WriteEnable, AddrIn, Flush, Depth, Overflow, Underflow
  );

  modport slave (
    input  PcIn, JmpEn, CondEn, CondSel, ZeroFlag, CarryFlag, CallEn, RetEn, Target, ClrErr,
    output WriteEnable, AddrIn, Flush, Depth, Overflow, Underflow
  );
endinterface

// File: rtl/jump_ctrl.sv
// Jump/branch/call/return controller: PC redirect with a two-cycle flush window and a
// return-address stack with sticky overflow/underflow flags.
module jump_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input logic         clk,
  input logic         nReset,
  jump_ctrl_if.slave  bus
);
  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = IdxW + 1;

  typedef enum logic [1:0] {StIdle, StRedirect, StSquash} state_e;

  state_e          state_q, state_d;
  logic            we_q, we_d;
  logic            flush_q, flush_d;
  logic [5:0]      addr_q, addr_d;
  logic [CntW-1:0] depth_q, depth_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic [5:0]      stack_q [DEPTH];

  logic            push;
  logic            taken;
  logic            cond_true;
  logic [5:0]      pc_next;
  logic [CntW-1:0] depth_m1;
  logic [IdxW-1:0] top_idx;

  assign pc_next  = bus.PcIn + 6'd1;
  assign depth_m1 = depth_q - CntW'(1);
  assign top_idx  = depth_m1[IdxW-1:0];

  always_comb begin
    cond_true = 1'b0;
    unique case (bus.CondSel)
      2'b00:   cond_true = bus.ZeroFlag;
      2'b01:   cond_true = ~bus.ZeroFlag;
      2'b10:   cond_true = bus.CarryFlag;
      2'b11:   cond_true = ~bus.CarryFlag;
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    flush_d = 1'b0;
    addr_d  = addr_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    taken   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Clear first so a coincident new error below still sets its flag.
        if (bus.ClrErr) begin
          ovf_d = 1'b0;
          unf_d = 1'b0;
        end
        if (bus.RetEn) begin
          if (depth_q == '0) begin
            unf_d = 1'b1;
          end else begin
            addr_d  = stack_q[top_idx];
            depth_d = depth_m1;
            taken   = 1'b1;
          end
        end else if (bus.CallEn) begin
          if (depth_q == CntW'(DEPTH)) begin
            ovf_d = 1'b1;
          end else begin
            push    = 1'b1;
            addr_d  = bus.Target;
            depth_d = depth_q + CntW'(1);
            taken   = 1'b1;
          end
        end else if (bus.JmpEn) begin
          addr_d = bus.Target;
          taken  = 1'b1;
        end else if (bus.CondEn && cond_true) begin
          addr_d = bus.Target;
          taken  = 1'b1;
        end
        if (taken) begin
          state_d = StRedirect;
          we_d    = 1'b1;
          flush_d = 1'b1;
        end
      end
      StRedirect: begin
        state_d = StSquash;
        flush_d = 1'b1;
      end
      StSquash: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      flush_q <= 1'b0;
      addr_q  <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      flush_q <= flush_d;
      addr_q  <= addr_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      if (push) begin
        stack_q[depth_q[IdxW-1:0]] <= pc_next;
      end
    end
  end

  assign bus.WriteEnable = we_q;
  assign bus.Flush       = flush_q;
  assign bus.AddrIn      = addr_q;
  assign bus.Depth       = depth_q;
  assign bus.Overflow    = ovf_q;
  assign bus.Underflow   = unf_q;
endmodule
